// File: rtl/pulse_conditioner.sv
// Input conditioner: synchroniser, glitch filter, edge-to-pulse with
// optional hold-off window and a saturating glitch counter.
module pulse_conditioner #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_CYCLES  = 16,
  parameter int unsigned EDGE_MODE      = 0,
  parameter int unsigned HOLDOFF_CYCLES = 0
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       raw_in,
  input  logic       enable_in,
  output logic       pulse_out,
  output logic       level_out,
  output logic       busy_out,
  output logic [7:0] glitch_cnt_out
);

  localparam int unsigned CW =
    (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] FLAST = CW'(FILTER_CYCLES - 1);
  localparam logic [31:0] HOLD_VAL = 32'(HOLDOFF_CYCLES);

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [CW-1:0]          fcnt_q, fcnt_d;
  logic                   level_q, level_d;
  logic                   level_prev_q;
  logic [7:0]             gcnt_q, gcnt_d;
  logic                   rise, fall, qual;
  state_e                 state_q, state_d;
  logic [31:0]            hcnt_q, hcnt_d;
  logic                   pulse_q, pulse_d;

  assign sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync_q       <= '0;
      fcnt_q       <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      gcnt_q       <= '0;
      state_q      <= IDLE;
      hcnt_q       <= '0;
      pulse_q      <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], raw_in};
      fcnt_q       <= fcnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
      gcnt_q       <= gcnt_d;
      state_q      <= state_d;
      hcnt_q       <= hcnt_d;
      pulse_q      <= pulse_d;
    end
  end

  // Acceptance at F-1 takes priority over a glitch ending that cycle.
  always_comb begin
    fcnt_d  = fcnt_q;
    level_d = level_q;
    gcnt_d  = gcnt_q;
    if (sync != level_q) begin
      if (fcnt_q == FLAST) begin
        level_d = ~level_q;
        fcnt_d  = '0;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end else if (fcnt_q != '0) begin
      fcnt_d = '0;
      if (gcnt_q != 8'hFF) gcnt_d = gcnt_q + 8'd1;
    end
  end

  assign rise = level_q & ~level_prev_q;
  assign fall = ~level_q & level_prev_q;
  assign qual = (EDGE_MODE == 0) ? rise :
                (EDGE_MODE == 1) ? fall : (rise | fall);

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    pulse_d = 1'b0;
    if (!enable_in) begin
      state_d = IDLE;
      hcnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (qual) begin
            pulse_d = 1'b1;
            hcnt_d  = HOLD_VAL;
            if (HOLD_VAL != 32'd0) state_d = HOLD;
          end
        end
        HOLD: begin
          if (hcnt_q <= 32'd1) begin
            state_d = IDLE;
            hcnt_d  = '0;
          end else begin
            hcnt_d = hcnt_q - 32'd1;
          end
        end
      endcase
    end
  end

  assign pulse_out      = pulse_q & enable_in;
  assign level_out      = level_q;
  assign busy_out       = (hcnt_q != 32'd0);
  assign glitch_cnt_out = gcnt_q;

endmodule

// File: tb/tb_pulse_conditioner.sv
// Directed bench for pulse_conditioner: three instances cover the
// default, both-edge and hold-off configurations.
module tb_pulse_conditioner;

  logic clk;
  logic rst_n;
  logic raw_a, en_a, pulse_a, level_a, busy_a;
  logic raw_b, en_b, pulse_b, level_b, busy_b;
  logic raw_c, en_c, pulse_c, level_c, busy_c;
  logic [7:0] gl_a, gl_b, gl_c;
  int pc_a, pc_b, pc_c;
  int n_checks, n_fail;

  pulse_conditioner u_a (
    .clk_in(clk), .rst_n_in(rst_n), .raw_in(raw_a),
    .enable_in(en_a), .pulse_out(pulse_a), .level_out(level_a),
    .busy_out(busy_a), .glitch_cnt_out(gl_a)
  );

  pulse_conditioner #(.EDGE_MODE(2)) u_b (
    .clk_in(clk), .rst_n_in(rst_n), .raw_in(raw_b),
    .enable_in(en_b), .pulse_out(pulse_b), .level_out(level_b),
    .busy_out(busy_b), .glitch_cnt_out(gl_b)
  );

  pulse_conditioner #(
    .FILTER_CYCLES(4), .EDGE_MODE(0), .HOLDOFF_CYCLES(100)
  ) u_c (
    .clk_in(clk), .rst_n_in(rst_n), .raw_in(raw_c),
    .enable_in(en_c), .pulse_out(pulse_c), .level_out(level_c),
    .busy_out(busy_c), .glitch_cnt_out(gl_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pulse_a) pc_a++;
    if (pulse_b) pc_b++;
    if (pulse_c) pc_c++;
  end

  task automatic test_reset();
    int p0;
    rst_n = 1'b0;
    raw_a = 0; raw_b = 0; raw_c = 0;
    en_a = 1; en_b = 1; en_c = 1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({pulse_a, level_a, busy_a} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_out: got %b want 000",
               {pulse_a, level_a, busy_a});
    end
    n_checks++;
    if (gl_a !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_gl: got %0d want 0", gl_a);
    end
    n_checks++;
    if (busy_c !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy_c: got %b want 0", busy_c);
    end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) raw_a = 1'b1;
    repeat (19) @(posedge clk);
    #1;
    n_checks++;
    if (pulse_a !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_pulse: got %b want 1", pulse_a);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pulse_a, level_a} !== 2'b00) begin
      n_fail++;
      $display("FAIL async_reset: got %b want 00",
               {pulse_a, level_a});
    end
    @(negedge clk) raw_a = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    p0 = pc_a;
    repeat (100) @(posedge clk);
    #1;
    n_checks++;
    if (pc_a != p0 || level_a !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: pulses %0d level %b want 0 0",
               pc_a - p0, level_a);
    end
  endtask

  task automatic test_defaults();
    logic exp_l, exp_p;
    @(negedge clk) raw_a = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      exp_l = (k >= 18);
      exp_p = (k == 19);
      n_checks++;
      if (level_a !== exp_l) begin
        n_fail++;
        $display("FAIL def_level edge %0d: got %b want %b",
                 k, level_a, exp_l);
      end
      n_checks++;
      if (pulse_a !== exp_p) begin
        n_fail++;
        $display("FAIL def_pulse edge %0d: got %b want %b",
                 k, pulse_a, exp_p);
      end
    end
    n_checks++;
    if (gl_a !== 8'd0) begin
      n_fail++;
      $display("FAIL def_glitch: got %0d want 0", gl_a);
    end
  endtask

  task automatic test_glitch();
    int p0;
    @(negedge clk) raw_a = 1'b0;
    repeat (40) @(negedge clk);
    n_checks++;
    if (level_a !== 1'b0) begin
      n_fail++;
      $display("FAIL fall_level: got %b want 0", level_a);
    end
    p0 = pc_a;
    raw_a = 1'b1;
    repeat (5) @(negedge clk);
    raw_a = 1'b0;
    repeat (30) @(negedge clk);
    n_checks++;
    if (gl_a !== 8'd1 || level_a !== 1'b0 || pc_a != p0) begin
      n_fail++;
      $display("FAIL glitch_one: gl %0d level %b pulses %0d want 1 0 0",
               gl_a, level_a, pc_a - p0);
    end
    for (int i = 0; i < 299; i++) begin
      raw_a = 1'b1;
      repeat (5) @(negedge clk);
      raw_a = 1'b0;
      repeat (10) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (gl_a !== 8'd255) begin
      n_fail++;
      $display("FAIL glitch_sat: got %0d want 255", gl_a);
    end
    n_checks++;
    if (level_a !== 1'b0 || pc_a != p0) begin
      n_fail++;
      $display("FAIL glitch_quiet: level %b pulses %0d want 0 0",
               level_a, pc_a - p0);
    end
  endtask

  task automatic test_both_edges();
    int p0;
    logic exp_p;
    p0 = pc_b;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk) raw_b = ~raw_b;
      for (int k = 1; k <= 40; k++) begin
        @(posedge clk);
        #1;
        exp_p = (k == 19);
        n_checks++;
        if (pulse_b !== exp_p) begin
          n_fail++;
          $display("FAIL both_pulse t%0d edge %0d: got %b want %b",
                   t, k, pulse_b, exp_p);
        end
      end
    end
    n_checks++;
    if (pc_b - p0 != 4) begin
      n_fail++;
      $display("FAIL both_count: got %0d want 4", pc_b - p0);
    end
  endtask

  task automatic test_holdoff();
    int p0;
    logic exp_p, exp_b;
    p0 = pc_c;
    for (int k = 1; k <= 130; k++) begin
      @(negedge clk) raw_c = (k <= 15) || (k >= 31 && k <= 60);
      @(posedge clk);
      #1;
      exp_p = (k == 7);
      exp_b = (k >= 7 && k <= 106);
      n_checks++;
      if (pulse_c !== exp_p || busy_c !== exp_b) begin
        n_fail++;
        $display("FAIL hold30 edge %0d: pulse/busy %b%b want %b%b",
                 k, pulse_c, busy_c, exp_p, exp_b);
      end
    end
    n_checks++;
    if (pc_c - p0 != 1) begin
      n_fail++;
      $display("FAIL hold30_count: got %0d want 1", pc_c - p0);
    end
    p0 = pc_c;
    for (int j = 1; j <= 240; j++) begin
      @(negedge clk) raw_c = (j <= 20) || (j >= 121 && j <= 140);
      @(posedge clk);
      #1;
      exp_p = (j == 7) || (j == 127);
      exp_b = (j >= 7 && j <= 106) || (j >= 127 && j <= 226);
      n_checks++;
      if (pulse_c !== exp_p || busy_c !== exp_b) begin
        n_fail++;
        $display("FAIL hold120 edge %0d: pulse/busy %b%b want %b%b",
                 j, pulse_c, busy_c, exp_p, exp_b);
      end
    end
    n_checks++;
    if (pc_c - p0 != 2) begin
      n_fail++;
      $display("FAIL hold120_count: got %0d want 2", pc_c - p0);
    end
  endtask

  task automatic test_enable();
    int p0;
    logic exp_p, exp_b, exp_l;
    @(negedge clk);
    en_c  = 1'b0;
    raw_c = 1'b1;
    p0 = pc_c;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      exp_l = (k >= 6);
      n_checks++;
      if (level_c !== exp_l || pulse_c !== 1'b0) begin
        n_fail++;
        $display("FAIL dis_edge %0d: level/pulse %b%b want %b0",
                 k, level_c, pulse_c, exp_l);
      end
    end
    n_checks++;
    if (pc_c != p0) begin
      n_fail++;
      $display("FAIL dis_count: got %0d want 0", pc_c - p0);
    end
    @(negedge clk) raw_c = 1'b0;
    repeat (20) @(negedge clk);
    p0 = pc_c;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      raw_c = (j <= 15) || (j >= 30);
      en_c  = !(j == 20 || j == 21);
      @(posedge clk);
      #1;
      exp_p = (j == 7) || (j == 36);
      exp_b = (j >= 7 && j <= 19) || (j >= 36);
      n_checks++;
      if (pulse_c !== exp_p || busy_c !== exp_b) begin
        n_fail++;
        $display("FAIL en_hold edge %0d: pulse/busy %b%b want %b%b",
                 j, pulse_c, busy_c, exp_p, exp_b);
      end
    end
    n_checks++;
    if (pc_c - p0 != 2) begin
      n_fail++;
      $display("FAIL en_hold_count: got %0d want 2", pc_c - p0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    pc_a = 0; pc_b = 0; pc_c = 0;
    test_reset();
    test_defaults();
    test_glitch();
    test_both_edges();
    test_holdoff();
    test_enable();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
